// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit that owns the HI/LO register pair.
//   Runs MULTU/MULT/DIVU/DIV over WIDTH iterations (radix-2 shift-add for
//   multiply, restoring shift-subtract for divide). Operands are reduced to
//   magnitudes when accepted, and the signs are reapplied in a final FIX cycle.
//   The unit also services mthi/mtlo writes while idle, and the control unit
//   can abort an in-flight operation with cancel.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   request an operation (accepted only when idle)
//   op[1:0]      in   00 multu, 01 mult, 10 divu, 11 div
//   a[WIDTH]     in   multiplicand / dividend (rs)
//   b[WIDTH]     in   multiplier / divisor (rt)
//   cancel       in   abort the in-flight operation, or suppress a start
//   hi_we        in   mthi write enable (idle only)
//   lo_we        in   mtlo write enable (idle only)
//   wdata        in   mthi/mtlo data
//   busy         out  operation in flight
//   done         out  one-cycle pulse after HI/LO take a result
//   div_by_zero  out  pulses with done for a divide by zero
//   hi, lo       out  HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_accept;
    logic               w_lastIter;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_divTmp;
    logic               w_divGe;
    logic [WIDTH-1:0]   w_divDiff;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    assign w_accept   = (r_state == ST_IDLE) && start && !cancel;
    assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

    // Signed ops work on magnitudes. The most negative value maps to itself,
    // which is still the correct unsigned magnitude.
    assign w_signA = op[0] & a[WIDTH-1];
    assign w_signB = op[0] & b[WIDTH-1];
    assign w_magA  = w_signA ? -a : a;
    assign w_magB  = w_signB ? -b : b;

    // Multiply step: the accumulator holds {partial product, remaining
    // multiplier bits}. The carry of the add shifts in from the top.
    assign w_addend  = r_acc[0] ? r_opnd : '0;
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // Divide step: the accumulator holds {partial remainder, dividend bits
    // becoming quotient bits}. Comparing WIDTH+1 bits keeps a zero divisor
    // well defined. It always subtracts, so the quotient becomes all ones and
    // the remainder ends up equal to the dividend.
    assign w_divTmp  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_divGe   = (w_divTmp >= {1'b0, r_opnd});
    assign w_divDiff = w_divTmp[WIDTH-1:0] - r_opnd;
    assign w_divNext = {(w_divGe ? w_divDiff : w_divTmp[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_divGe};

    // Sign correction applied in FIX.
    assign w_prod  = r_negRes ? -r_acc : r_acc;
    assign w_quot  = r_acc[WIDTH-1:0];
    assign w_rem   = r_acc[2*WIDTH-1:WIDTH];
    assign w_fixHi = r_isDiv ? (r_negRem ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    assign w_fixLo = r_isDiv ? (r_divZero ? '1 : (r_negRes ? -w_quot : w_quot))
                             : w_prod[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. cancel pulls CALC/FIX straight back to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = ST_CALC;
            ST_CALC: begin
                if (cancel) begin
                    w_nextState = ST_IDLE;
                end else if (w_lastIter) begin
                    w_nextState = ST_FIX;
                end
            end
            ST_FIX:  w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write and HI/LO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_isDiv   <= op[1];
                        r_negRes  <= w_signA ^ w_signB;
                        r_negRem  <= w_signA;
                        r_divZero <= op[1] & (b == '0);
                        if (op[1]) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_magA};
                            r_opnd <= w_magB;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_magB};
                            r_opnd <= w_magA;
                        end
                    end
                end
                ST_CALC: begin
                    if (!cancel) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_acc <= r_isDiv ? w_divNext : w_mulNext;
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        r_hi   <= w_fixHi;
                        r_lo   <= w_fixLo;
                        r_done <= 1'b1;
                        r_dbz  <= r_divZero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle, parametrised multiply/divide unit that owns the HI/LO register pair. It replaces the single-cycle combinational MULT/DIV path and the separate HI/LO register in the CPU datapath.
- Issues MULT/MULTU/DIV/DIVU over WIDTH iterations with a start/busy/done handshake, which lets the control unit stall on mfhi/mflo.
- Also services mthi/mtlo writes and supports a cancel for exception flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; accepted only while busy=0.
- op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- cancel  in  1  abort the in-flight operation (exception flush).
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO updated by a completed operation.
- div_by_zero  out  1  pulses with done when a div/divu had b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): state IDLE; hi=0, lo=0; busy=0, done=0, div_by_zero=0; counter and internal operand registers cleared.
- States are IDLE, CALC and FIX.
- IDLE:
  - When start=1 and cancel=0 at edge k, latch |a| and |b| (magnitudes when op[0]=1, raw values otherwise), the result signs and op, set cnt=0 and go to CALC.
  - busy=1 from edge k.
- CALC:
  - Exactly WIDTH iterations, one per edge.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - After the WIDTH-th iteration (edge k+WIDTH) go to FIX.
- FIX (edge k+WIDTH+1):
  - Apply sign correction and write HI/LO.
  - Assert done=1 (and div_by_zero if applicable) for exactly the following cycle.
  - busy=0 and state=IDLE from that same edge.
  - Result latency is WIDTH+1 edges after acceptance (33 for WIDTH=32).
- Results:
  - mult/multu: {hi,lo} is the full 2*WIDTH-bit product.
  - div/divu: lo is the quotient, hi is the remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Signed overflow (a = most negative, b = -1): lo = most negative, hi = 0. No trap.
  - Divide by zero (b=0, op 10/11): hi = a (raw), lo = all ones, div_by_zero pulses with done. The unit still takes the full latency.
- start while busy=1 is ignored; no queueing.
- The caller must hold off a new start until it has seen done or busy=0.
- cancel:
  - In CALC or FIX, cancel forces IDLE at the next edge, busy=0, no done, and HI/LO unchanged.
  - cancel with start in IDLE means no operation is started.
- hi_we/lo_we:
  - In IDLE, write wdata at the edge. This takes effect even in the same cycle as an accepted start; the operation later overwrites HI/LO at FIX.
  - While busy=1, hi_we/lo_we are ignored. The control unit must stall mthi/mtlo, mfhi and mflo while busy.
- Operands a and b may change after acceptance without affecting the result.
- done and div_by_zero are registered outputs with no combinational paths from inputs.
- hi and lo are direct register outputs.

Test Plan:
- Reset, then multu a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- mult a=0xFFFFFFFA (-6), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42). Then div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. Then divu a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1 with done.
- Start divu 100/7, assert cancel at cycle 10 -> busy drops next edge, done never pulses, HI/LO keep prior values. A restart then yields lo=14, hi=2.
- While busy: pulse start with other operands, and assert hi_we with wdata=0xDEADBEEF -> both are ignored, and the original result is written. In IDLE, lo_we with 0x55 -> lo=0x55 the next cycle.
- Assert rst mid-CALC (asynchronously, between edges) -> hi, lo, busy and done are 0 immediately. Rerun with WIDTH=8: multu 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 edges.
